if_fetch_pc: RTL and testbench

- IF-stage PC generator with a direct-mapped branch history table (BHT) and branch target buffer (BTB).
- Drives the instruction-memory address each cycle.
- Produces IF_take, the predicted-taken flag the IF/ID register captures alongside the fetched instruction.
- Accepts redirects from ID (jump) and EX/MEM (mispredict flush), and trains the predictor from resolved branches.

---
 rtl/if_fetch_pc_pkg.sv | 34 +++
 rtl/if_bht_btb.sv | 73 +++++++
 rtl/if_fetch_pc.sv | 84 ++++++++
 tb/tb_if_fetch_pc.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pc_pkg.sv
// Shared types for the IF-stage PC generator: counter encodings, next-PC select
// and the saturating-counter update rule.
package if_fetch_pc_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    typedef enum logic [2:0] {
        SEL_FLUSH,
        SEL_HOLD,
        SEL_JUMP,
        SEL_PRED,
        SEL_SEQ
    } npc_sel_e;

    // Two-bit saturating counter step toward the resolved outcome.
    function automatic ctr_e ctr_update(input ctr_e c, input logic taken);
        logic [1:0] v;
        v = c;
        if (taken) begin
            if (c != ST) v = v + 2'd1;
        end else begin
            if (c != SNT) v = v - 2'd1;
        end
        return ctr_e'(v);
    endfunction

endpackage

// File: rtl/if_bht_btb.sv
// Direct-mapped branch history table plus branch target buffer with a
// combinational lookup port and a single edge-triggered training port.
module if_bht_btb
    import if_fetch_pc_pkg::*;
#(
    parameter int unsigned BHT_BITS = 4,
    parameter int unsigned TAG_W    = 30 - BHT_BITS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] lookup_pc,
    output logic        lookup_take,
    output logic [31:0] lookup_target,
    input  logic        train_en,
    input  logic [31:0] train_pc,
    input  logic        train_taken,
    input  logic [31:0] train_target
);

    localparam int unsigned ENTRIES = 1 << BHT_BITS;

    ctr_e              ctr_q    [ENTRIES];
    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];

    logic [BHT_BITS-1:0] rd_idx;
    logic [TAG_W-1:0]    rd_tag;
    logic                rd_hit;
    logic [BHT_BITS-1:0] wr_idx;
    logic [TAG_W-1:0]    wr_tag;
    logic                wr_hit;
    logic [3:0]          unused_align_bits;

    // Word alignment is assumed; the low address bits take no part in index or tag.
    assign unused_align_bits = {lookup_pc[1:0], train_pc[1:0]};

    assign rd_idx = lookup_pc[BHT_BITS+1:2];
    assign rd_tag = lookup_pc[31:BHT_BITS+2];
    assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

    assign lookup_take   = rd_hit && ctr_q[rd_idx][1];
    assign lookup_target = rd_hit ? target_q[rd_idx] : '0;

    assign wr_idx = train_pc[BHT_BITS+1:2];
    assign wr_tag = train_pc[31:BHT_BITS+2];
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    // Lookup reads the registered arrays, so a same-index update shows up next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_q[i]    <= WNT;
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else if (train_en) begin
            if (wr_hit) begin
                ctr_q[wr_idx] <= ctr_update(ctr_q[wr_idx], train_taken);
                if (train_taken) begin
                    target_q[wr_idx] <= train_target;
                end
            end else if (train_taken) begin
                valid_q[wr_idx]  <= 1'b1;
                tag_q[wr_idx]    <= wr_tag;
                ctr_q[wr_idx]    <= WT;
                target_q[wr_idx] <= train_target;
            end
        end
    end

endmodule

// File: rtl/if_fetch_pc.sv
// IF-stage PC register and next-PC priority mux; branch prediction comes from
// the if_bht_btb table indexed by the current fetch PC.
module if_fetch_pc
    import if_fetch_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned BHT_BITS = 4,
    parameter int unsigned TAG_W    = 30 - BHT_BITS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        EX_MEM_stall,
    input  logic        EX_MEM_flush,
    input  logic [31:0] EX_MEM_redirect_pc,
    input  logic        ID_EX_branch,
    input  logic [31:0] ID_EX_target,
    input  logic        EX_MEM_br_valid,
    input  logic [31:0] EX_MEM_br_pc,
    input  logic        EX_MEM_br_taken,
    input  logic [31:0] EX_MEM_br_target,
    output logic [31:0] inst_mem_addr,
    output logic [31:0] IF_pc,
    output logic        IF_take,
    output logic [31:0] IF_pred_target
);

    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic        pred_take;
    logic [31:0] pred_target;
    logic        train_en;
    npc_sel_e    sel;

    // A stalled strobe is held upstream, so gating by stall trains it exactly once.
    assign train_en = EX_MEM_br_valid && !EX_MEM_stall;

    if_bht_btb #(
        .BHT_BITS (BHT_BITS),
        .TAG_W    (TAG_W)
    ) u_bht_btb (
        .clk           (clk),
        .reset         (reset),
        .lookup_pc     (pc_q),
        .lookup_take   (pred_take),
        .lookup_target (pred_target),
        .train_en      (train_en),
        .train_pc      (EX_MEM_br_pc),
        .train_taken   (EX_MEM_br_taken),
        .train_target  (EX_MEM_br_target)
    );

    always_comb begin
        sel = SEL_SEQ;
        if (EX_MEM_flush)      sel = SEL_FLUSH;
        else if (EX_MEM_stall) sel = SEL_HOLD;
        else if (ID_EX_branch) sel = SEL_JUMP;
        else if (pred_take)    sel = SEL_PRED;
    end

    always_comb begin
        pc_next = pc_q + 32'd4;
        case (sel)
            SEL_FLUSH: pc_next = EX_MEM_redirect_pc;
            SEL_HOLD:  pc_next = pc_q;
            SEL_JUMP:  pc_next = ID_EX_target;
            SEL_PRED:  pc_next = pred_target;
            default:   pc_next = pc_q + 32'd4;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    assign inst_mem_addr  = pc_q;
    assign IF_pc          = pc_q;
    assign IF_take        = pred_take;
    assign IF_pred_target = pred_target;

endmodule

// File: tb/tb_if_fetch_pc.sv
// Scoreboard bench for if_fetch_pc: stimulus pushes the expected per-cycle fetch
// outputs from a reference model, a negedge monitor pops and compares them.
module tb_if_fetch_pc;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush, jump, bv, btaken;
    logic [31:0] redir_pc, jump_tgt, bpc, btgt;
    logic [31:0] inst_mem_addr, IF_pc, IF_pred_target;
    logic        IF_take;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic        take;
        logic [31:0] tgt;
    } exp_t;

    exp_t exp_q[$];

    // Reference predictor: 16 entries, counter kept as an integer 0..3.
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    int          m_ctr   [16];
    logic [31:0] m_tgt   [16];
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    if_fetch_pc #(
        .RESET_PC (32'h0000_0000),
        .BHT_BITS (4)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .EX_MEM_stall       (stall),
        .EX_MEM_flush       (flush),
        .EX_MEM_redirect_pc (redir_pc),
        .ID_EX_branch       (jump),
        .ID_EX_target       (jump_tgt),
        .EX_MEM_br_valid    (bv),
        .EX_MEM_br_pc       (bpc),
        .EX_MEM_br_taken    (btaken),
        .EX_MEM_br_target   (btgt),
        .inst_mem_addr      (inst_mem_addr),
        .IF_pc              (IF_pc),
        .IF_take            (IF_take),
        .IF_pred_target     (IF_pred_target)
    );

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc / 4) % 16;
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / 64;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
            m_ctr[i]   = 1;
            m_tgt[i]   = 0;
        end
    endtask

    task automatic model_lookup(output logic take, output logic [31:0] tgt);
        int unsigned i;
        bit hit;
        i    = idx_of(m_pc);
        hit  = m_valid[i] && (m_tag[i] == tag_of(m_pc));
        take = hit && (m_ctr[i] >= 2);
        tgt  = hit ? m_tgt[i] : 32'h0;
    endtask

    task automatic model_advance(input logic take, input logic [31:0] ptgt);
        int unsigned i;
        if (flush)     m_pc = redir_pc;
        else if (stall) m_pc = m_pc;
        else if (jump) m_pc = jump_tgt;
        else if (take) m_pc = ptgt;
        else           m_pc = m_pc + 32'd4;
        if (bv && !stall) begin
            i = idx_of(bpc);
            if (m_valid[i] && m_tag[i] == tag_of(bpc)) begin
                if (btaken) begin
                    m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                    m_tgt[i] = btgt;
                end else begin
                    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                end
            end else if (btaken) begin
                m_valid[i] = 1;
                m_tag[i]   = tag_of(bpc);
                m_ctr[i]   = 2;
                m_tgt[i]   = btgt;
            end
        end
    endtask

    task automatic idle();
        stall = 0; flush = 0; jump = 0; bv = 0; btaken = 0;
        redir_pc = 0; jump_tgt = 0; bpc = 0; btgt = 0;
    endtask

    // One clock: queue this cycle's expected outputs, then advance the model at the edge.
    task automatic step();
        exp_t e;
        if (!reset) model_reset();
        e.pc = m_pc;
        model_lookup(e.take, e.tgt);
        exp_q.push_back(e);
        @(posedge clk);
        if (reset) model_advance(e.take, e.tgt);
        #1;
    endtask

    task automatic redirect(input logic [31:0] pc);
        idle(); flush = 1; redir_pc = pc; step(); idle();
    endtask

    task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        idle(); bv = 1; bpc = pc; btaken = taken; btgt = tgt; step(); idle();
    endtask

    task automatic async_reset();
        idle();
        reset = 0;
        model_reset();
        step(); step();
        reset = 1;
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check32("inst_mem_addr", inst_mem_addr, e.pc);
                check32("IF_pc", IF_pc, e.pc);
                check32("IF_take", {31'h0, IF_take}, {31'h0, e.take});
                check32("IF_pred_target", IF_pred_target, e.tgt);
            end
        end
    end

    initial begin : stimulus
        int budget;
        idle();
        reset = 0;
        model_reset();
        @(posedge clk); #1;
        step(); step();
        reset = 1;
        step(); step();                     // 0x0 -> 0x4 -> 0x8

        // Jump at 0x8, first blocked by stall, then taken.
        idle(); jump = 1; jump_tgt = 32'h100; stall = 1; step();
        stall = 0; step(); idle();

        // Flush beats stall and jump.
        idle(); flush = 1; redir_pc = 32'h200; stall = 1; jump = 1; jump_tgt = 32'h300; step();
        idle(); step();

        // Allocate 0x10 -> 0x80, then fetch through it.
        train(32'h10, 1, 32'h80);
        redirect(32'h8);
        step(); step(); step();

        // Saturate, then decay to weakly not-taken.
        repeat (3) train(32'h10, 1, 32'h80);
        repeat (2) train(32'h10, 0, 32'h0);
        redirect(32'h10);
        step(); step();

        // A stalled strobe trains once when the stall drops.
        idle(); bv = 1; bpc = 32'h10; btaken = 1; btgt = 32'h84; stall = 1;
        step(); step(); step();
        stall = 0; step(); idle();
        redirect(32'h10);
        step(); step();

        // Alias: 0x50 shares the index of 0x10 with a different tag.
        train(32'h50, 1, 32'h90);
        redirect(32'h10);
        step(); step();
        redirect(32'h50);
        step(); step();

        // Sequential wrap.
        redirect(32'hFFFF_FFFC);
        step(); step();

        // Flush and training together, then an asynchronous reset mid-run.
        idle(); flush = 1; redir_pc = 32'h20; bv = 1; bpc = 32'h20; btaken = 1; btgt = 32'h40; step();
        idle(); step(); step();
        async_reset();
        step(); step();

        for (int n = 0; n < 1500; n++) begin
            stall  = ($urandom_range(0, 99) < 15);
            flush  = ($urandom_range(0, 99) < 8);
            redir_pc = ($urandom_range(0, 99) < 5) ? 32'hFFFF_FFF0 : ($urandom_range(0, 63) << 2);
            jump   = ($urandom_range(0, 99) < 8);
            jump_tgt = $urandom_range(0, 63) << 2;
            bv     = ($urandom_range(0, 99) < 35);
            bpc    = $urandom_range(0, 31) << 2;
            btaken = $urandom_range(0, 1);
            btgt   = $urandom_range(0, 63) << 2;
            if ($urandom_range(0, 299) == 0) async_reset();
            else step();
        end
        idle();
        step();

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        @(posedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
